// File: rtl/merge_pass_sequencer.sv
// -----------------------------------------------------------------------------
// merge_pass_sequencer
//   Multi-pass address sequencer for the merge-sort kernel. Each pass reads
//   sorted runs from one buffer and writes merged runs to the other, swapping
//   buffers every pass. Runs are handed to the read engine in groups of
//   NUM_LEAVES, one run per merge-tree leaf, and the write engine gets one
//   destination base per pass. ap_done pulses after the final pass.
//
//   Optional feature macro: MERGE_SEQ_PERF_CNT_EN (adds cycle counters).
//
// Ports
//   aclk, ap_rst_n      clock, asynchronous active-low reset
//   ap_start            start pulse, sampled only while idle
//   i_num_pass          number of passes (clamped to MAX_PASS)
//   i_ptr_src/i_ptr_dst buffer A (input data) / buffer B base addresses
//   i_xfer_bytes        total bytes, a multiple of INIT_CHUNK_BYTES
//   i_read_done         current group fully read
//   i_write_done        current pass fully written
//   o_read_start        pulse: o_leaf_addr/o_leaf_bytes valid for a group
//   o_leaf_addr/bytes   per-leaf run start address and length (0 = empty)
//   o_write_start       pulse: o_write_addr valid for a pass
//   o_write_addr        destination base of the current pass
//   o_init_pass         high throughout pass 0
//   o_pass_idx          current pass index
//   o_busy              high from leaving idle until ap_done
//   ap_done             one-cycle completion pulse
//   o_pass_cycles       (perf) cycles from PASS_INIT to i_write_done
//   o_total_cycles      (perf) cycles from ap_start to ap_done
// -----------------------------------------------------------------------------
module merge_pass_sequencer #(
    parameter int NUM_LEAVES       = 16,
    parameter int ADDR_W           = 64,
    parameter int XFER_W           = 64,
    parameter int INIT_CHUNK_BYTES = 64,
    parameter int MAX_PASS         = 8
) (
    input  logic                           aclk,
    input  logic                           ap_rst_n,
    input  logic                           ap_start,
    input  logic [7:0]                     i_num_pass,
    input  logic [ADDR_W-1:0]              i_ptr_src,
    input  logic [ADDR_W-1:0]              i_ptr_dst,
    input  logic [XFER_W-1:0]              i_xfer_bytes,
    input  logic                           i_read_done,
    input  logic                           i_write_done,
    output logic                           o_read_start,
    output logic [NUM_LEAVES*ADDR_W-1:0]   o_leaf_addr,
    output logic [NUM_LEAVES*XFER_W-1:0]   o_leaf_bytes,
    output logic                           o_write_start,
    output logic [ADDR_W-1:0]              o_write_addr,
    output logic                           o_init_pass,
    output logic [7:0]                     o_pass_idx,
    output logic                           o_busy,
    output logic                           ap_done
`ifdef MERGE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                    o_pass_cycles,
    output logic [31:0]                    o_total_cycles
`endif
);

    localparam int LOG2L = $clog2(NUM_LEAVES);
    // Offsets can reach (NUM_LEAVES+1)*xfer before comparison; extra bits prevent wrap.
    localparam int OFF_W = XFER_W + 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PASS_INIT = 3'd1,
        S_GRP_CALC  = 3'd2,
        S_GRP_ISSUE = 3'd3,
        S_GRP_WAIT  = 3'd4,
        S_PASS_WAIT = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [ADDR_W-1:0]               r_ptr_a;
    logic [ADDR_W-1:0]               r_ptr_b;
    logic [XFER_W-1:0]               r_xfer;
    logic [XFER_W-1:0]               r_run;
    logic [7:0]                      r_num;
    logic [7:0]                      r_pass;
    logic [OFF_W-1:0]                r_grp_off;
    logic                            r_wr_seen;

    logic [ADDR_W-1:0]               w_ptr_a_nxt;
    logic [ADDR_W-1:0]               w_ptr_b_nxt;
    logic [XFER_W-1:0]               w_xfer_nxt;
    logic [XFER_W-1:0]               w_run_nxt;
    logic [7:0]                      w_num_nxt;
    logic [7:0]                      w_pass_nxt;
    logic [OFF_W-1:0]                w_grp_off_nxt;
    logic                            w_wr_seen_nxt;
    logic [ADDR_W-1:0]               w_write_addr_nxt;
    logic [NUM_LEAVES*ADDR_W-1:0]    w_leaf_addr_nxt;
    logic [NUM_LEAVES*XFER_W-1:0]    w_leaf_bytes_nxt;
    logic                            w_init_pass_nxt;

    logic                            w_start_ok;
    logic                            w_zero_job;
    logic [7:0]                      w_num_clamp;
    logic [XFER_W-1:0]               w_init_run;
    logic [OFF_W-1:0]                w_grp_off_inc;
    logic                            w_last_grp;
    logic                            w_wr_any;
    logic                            w_last_pass;
    logic [ADDR_W-1:0]               w_src;
    logic [OFF_W-1:0]                w_leaf_off;

    // Offset of leaf idx inside a group: base + idx*run built from shifted adds.
    function automatic logic [OFF_W-1:0] leaf_offset(input logic [OFF_W-1:0] base,
                                                     input logic [XFER_W-1:0] run,
                                                     input logic [6:0] idx);
        logic [OFF_W-1:0] acc;
        acc = base;
        for (int b = 0; b < 7; b++) begin
            if (idx[b]) begin
                acc = acc + (OFF_W'(run) << b);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // Leaf length: empty past the end, otherwise the run clipped to the remaining bytes.
    function automatic logic [XFER_W-1:0] leaf_len(input logic [OFF_W-1:0] off,
                                                   input logic [XFER_W-1:0] run,
                                                   input logic [XFER_W-1:0] xfer);
        logic [XFER_W-1:0] rem;
        if (off >= OFF_W'(xfer)) begin
            return {XFER_W{1'b0}};
        end else begin
            rem = xfer - off[XFER_W-1:0];
            if (rem < run) begin
                return rem;
            end else begin
                return run;
            end
        end
    endfunction

    // Run length of the following pass, saturated at xfer instead of wrapping.
    function automatic logic [XFER_W-1:0] next_run(input logic [XFER_W-1:0] run,
                                                   input logic [XFER_W-1:0] xfer);
        if (run > (xfer >> LOG2L)) begin
            return xfer;
        end else begin
            return run << LOG2L;
        end
    endfunction

    assign w_start_ok    = (r_state == S_IDLE) && ap_start;
    assign w_zero_job    = (i_num_pass == 8'd0) || (i_xfer_bytes == {XFER_W{1'b0}});
    assign w_num_clamp   = (i_num_pass > 8'(MAX_PASS)) ? 8'(MAX_PASS) : i_num_pass;
    assign w_init_run    = (XFER_W'(INIT_CHUNK_BYTES) > i_xfer_bytes) ? i_xfer_bytes
                                                                      : XFER_W'(INIT_CHUNK_BYTES);
    assign w_grp_off_inc = r_grp_off + (OFF_W'(r_run) << LOG2L);
    assign w_last_grp    = (w_grp_off_inc >= OFF_W'(r_xfer));
    assign w_wr_any      = i_write_done || r_wr_seen;
    assign w_last_pass   = ((r_pass + 8'd1) == r_num);
    // Even passes read buffer A, odd passes read buffer B.
    assign w_src         = r_pass[0] ? r_ptr_b : r_ptr_a;

    // State register.
    always_ff @(posedge aclk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = w_zero_job ? S_DONE : S_PASS_INIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PASS_INIT: w_state_nxt = S_GRP_CALC;
            S_GRP_CALC:  w_state_nxt = S_GRP_ISSUE;
            S_GRP_ISSUE: w_state_nxt = S_GRP_WAIT;
            S_GRP_WAIT: begin
                if (i_read_done) begin
                    w_state_nxt = w_last_grp ? S_PASS_WAIT : S_GRP_CALC;
                end else begin
                    w_state_nxt = S_GRP_WAIT;
                end
            end
            S_PASS_WAIT: begin
                if (w_wr_any) begin
                    w_state_nxt = w_last_pass ? S_DONE : S_PASS_INIT;
                end else begin
                    w_state_nxt = S_PASS_WAIT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath next values: job latch, pass/group bookkeeping, leaf calculation.
    always_comb begin
        w_ptr_a_nxt      = r_ptr_a;
        w_ptr_b_nxt      = r_ptr_b;
        w_xfer_nxt       = r_xfer;
        w_num_nxt        = r_num;
        w_pass_nxt       = r_pass;
        w_run_nxt        = r_run;
        w_grp_off_nxt    = r_grp_off;
        w_wr_seen_nxt    = r_wr_seen;
        w_write_addr_nxt = o_write_addr;
        w_leaf_addr_nxt  = o_leaf_addr;
        w_leaf_bytes_nxt = o_leaf_bytes;
        w_leaf_off       = {OFF_W{1'b0}};

        if (w_start_ok) begin
            w_ptr_a_nxt = i_ptr_src;
            w_ptr_b_nxt = i_ptr_dst;
            w_xfer_nxt  = i_xfer_bytes;
            w_num_nxt   = w_num_clamp;
            w_pass_nxt  = 8'd0;
            w_run_nxt   = w_init_run;
        end else if ((r_state == S_PASS_WAIT) && w_wr_any) begin
            w_pass_nxt = r_pass + 8'd1;
            w_run_nxt  = next_run(r_run, r_xfer);
        end else begin
            w_pass_nxt = r_pass;
        end

        if (w_state_nxt == S_PASS_INIT) begin
            w_grp_off_nxt = {OFF_W{1'b0}};
        end else if ((r_state == S_GRP_WAIT) && i_read_done) begin
            w_grp_off_nxt = w_grp_off_inc;
        end else begin
            w_grp_off_nxt = r_grp_off;
        end

        // An early write-done seen while groups are still being read is kept for PASS_WAIT.
        if ((w_state_nxt == S_PASS_INIT) || (r_state == S_IDLE)) begin
            w_wr_seen_nxt = 1'b0;
        end else if ((r_state == S_GRP_WAIT) && i_write_done) begin
            w_wr_seen_nxt = 1'b1;
        end else begin
            w_wr_seen_nxt = r_wr_seen;
        end

        // Destination is the buffer not being read by the upcoming pass.
        if (w_state_nxt == S_PASS_INIT) begin
            w_write_addr_nxt = w_pass_nxt[0] ? w_ptr_a_nxt : w_ptr_b_nxt;
        end else begin
            w_write_addr_nxt = o_write_addr;
        end

        if (r_state == S_GRP_CALC) begin
            for (int l = 0; l < NUM_LEAVES; l++) begin
                w_leaf_off = leaf_offset(r_grp_off, r_run, 7'(l));
                w_leaf_addr_nxt[l*ADDR_W +: ADDR_W]  = w_src + ADDR_W'(w_leaf_off[XFER_W-1:0]);
                w_leaf_bytes_nxt[l*XFER_W +: XFER_W] = leaf_len(w_leaf_off, r_run, r_xfer);
            end
        end else begin
            w_leaf_addr_nxt  = o_leaf_addr;
            w_leaf_bytes_nxt = o_leaf_bytes;
        end

        w_init_pass_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE) &&
                          (w_pass_nxt == 8'd0);
    end

    // Datapath and registered outputs.
    always_ff @(posedge aclk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ptr_a       <= {ADDR_W{1'b0}};
            r_ptr_b       <= {ADDR_W{1'b0}};
            r_xfer        <= {XFER_W{1'b0}};
            r_run         <= {XFER_W{1'b0}};
            r_num         <= 8'd0;
            r_pass        <= 8'd0;
            r_grp_off     <= {OFF_W{1'b0}};
            r_wr_seen     <= 1'b0;
            o_read_start  <= 1'b0;
            o_leaf_addr   <= {(NUM_LEAVES*ADDR_W){1'b0}};
            o_leaf_bytes  <= {(NUM_LEAVES*XFER_W){1'b0}};
            o_write_start <= 1'b0;
            o_write_addr  <= {ADDR_W{1'b0}};
            o_init_pass   <= 1'b0;
            o_pass_idx    <= 8'd0;
            o_busy        <= 1'b0;
            ap_done       <= 1'b0;
        end else begin
            r_ptr_a       <= w_ptr_a_nxt;
            r_ptr_b       <= w_ptr_b_nxt;
            r_xfer        <= w_xfer_nxt;
            r_run         <= w_run_nxt;
            r_num         <= w_num_nxt;
            r_pass        <= w_pass_nxt;
            r_grp_off     <= w_grp_off_nxt;
            r_wr_seen     <= w_wr_seen_nxt;
            o_read_start  <= (w_state_nxt == S_GRP_ISSUE);
            o_leaf_addr   <= w_leaf_addr_nxt;
            o_leaf_bytes  <= w_leaf_bytes_nxt;
            o_write_start <= (w_state_nxt == S_PASS_INIT);
            o_write_addr  <= w_write_addr_nxt;
            o_init_pass   <= w_init_pass_nxt;
            o_pass_idx    <= w_pass_nxt;
            o_busy        <= (w_state_nxt != S_IDLE);
            ap_done       <= (r_state == S_DONE);
        end
    end

`ifdef MERGE_SEQ_PERF_CNT_EN
    logic [31:0] r_pass_cnt;
    logic [31:0] r_tot_cnt;
    logic        w_wd_first;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    // First write-done of a pass, whether early (GRP_WAIT) or in PASS_WAIT.
    assign w_wd_first = i_write_done && !r_wr_seen &&
                        ((r_state == S_GRP_WAIT) || (r_state == S_PASS_WAIT));

    // Pass and job cycle counters; PASS_INIT cycle counts as the first cycle.
    always_ff @(posedge aclk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_pass_cnt     <= 32'd0;
            r_tot_cnt      <= 32'd0;
            o_pass_cycles  <= 32'd0;
            o_total_cycles <= 32'd0;
        end else begin
            if (r_state == S_PASS_INIT) begin
                r_pass_cnt <= 32'd1;
            end else if (r_state != S_IDLE) begin
                r_pass_cnt <= sat_inc(r_pass_cnt);
            end else begin
                r_pass_cnt <= r_pass_cnt;
            end

            if (w_start_ok) begin
                r_tot_cnt <= 32'd1;
            end else if (r_state != S_IDLE) begin
                r_tot_cnt <= sat_inc(r_tot_cnt);
            end else begin
                r_tot_cnt <= r_tot_cnt;
            end

            if (w_wd_first) begin
                o_pass_cycles <= r_pass_cnt;
            end else begin
                o_pass_cycles <= o_pass_cycles;
            end

            if (r_state == S_DONE) begin
                o_total_cycles <= sat_inc(r_tot_cnt);
            end else begin
                o_total_cycles <= o_total_cycles;
            end
        end
    end
`endif

endmodule

// File: tb/tb_merge_pass_sequencer.sv
module tb_merge_pass_sequencer;
    localparam int L    = 16;
    localparam int AW   = 64;
    localparam int XW   = 64;
    localparam int INIT = 64;
    localparam int MAXP = 8;

    logic              aclk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              ap_start = 1'b0;
    logic [7:0]        i_num_pass = 8'd0;
    logic [AW-1:0]     i_ptr_src = '0;
    logic [AW-1:0]     i_ptr_dst = '0;
    logic [XW-1:0]     i_xfer_bytes = '0;
    logic              i_read_done = 1'b0;
    logic              i_write_done = 1'b0;
    logic              o_read_start;
    logic [L*AW-1:0]   o_leaf_addr;
    logic [L*XW-1:0]   o_leaf_bytes;
    logic              o_write_start;
    logic [AW-1:0]     o_write_addr;
    logic              o_init_pass;
    logic [7:0]        o_pass_idx;
    logic              o_busy;
    logic              ap_done;
`ifdef MERGE_SEQ_PERF_CNT_EN
    logic [31:0]       o_pass_cycles;
    logic [31:0]       o_total_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int rs_cnt  = 0;
    int ws_cnt  = 0;
    int dn_cnt  = 0;

    merge_pass_sequencer #(
        .NUM_LEAVES(L), .ADDR_W(AW), .XFER_W(XW), .INIT_CHUNK_BYTES(INIT), .MAX_PASS(MAXP)
    ) dut (
        .aclk(aclk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .i_num_pass(i_num_pass), .i_ptr_src(i_ptr_src), .i_ptr_dst(i_ptr_dst),
        .i_xfer_bytes(i_xfer_bytes), .i_read_done(i_read_done), .i_write_done(i_write_done),
        .o_read_start(o_read_start), .o_leaf_addr(o_leaf_addr), .o_leaf_bytes(o_leaf_bytes),
        .o_write_start(o_write_start), .o_write_addr(o_write_addr), .o_init_pass(o_init_pass),
        .o_pass_idx(o_pass_idx), .o_busy(o_busy), .ap_done(ap_done)
`ifdef MERGE_SEQ_PERF_CNT_EN
        , .o_pass_cycles(o_pass_cycles), .o_total_cycles(o_total_cycles)
`endif
    );

    always #5 aclk = ~aclk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge aclk) begin
        if (o_read_start)  rs_cnt++;
        if (o_write_start) ws_cnt++;
        if (ap_done)       dn_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: run length of pass p = INIT * L^p, never larger than the transfer.
    function automatic longint run_len(input int p, input longint xfer);
        longint r;
        r = INIT;
        if (r > xfer) r = xfer;
        for (int i = 0; i < p; i++) begin
            r = r * L;
            if (r > xfer) r = xfer;
        end
        return r;
    endfunction

    task automatic pulse_reset();
        @(negedge aclk);
        ap_rst_n = 1'b0;
        i_read_done = 1'b0;
        i_write_done = 1'b0;
        ap_start = 1'b0;
        @(negedge aclk);
        ap_rst_n = 1'b1;
        @(negedge aclk);
    endtask

    // One complete job. wmode: 0 write-done after reads, 1 with last read-done,
    // 2 before last read-done, -1 random per pass. poke: restart attempt mid-job.
    task automatic run_job(input longint xfer, input int np, input logic [63:0] pa,
                           input logic [63:0] pb, input int wmode, input bit poke);
        int eff, rs0, ws0, dn0, lat, exp_rs, cyc, ng, mode;
        bit err, last;
        longint r, off, eb;
        logic [63:0] src, dst, ea;
        eff = (np > MAXP) ? MAXP : np;
        rs0 = rs_cnt; ws0 = ws_cnt; dn0 = dn_cnt;
        exp_rs = 0; err = 1'b0;
        @(negedge aclk);
        i_num_pass = 8'(np); i_ptr_src = pa; i_ptr_dst = pb; i_xfer_bytes = xfer;
        ap_start = 1'b1;
        @(negedge aclk);
        ap_start = 1'b0;
        cyc = 1;
        if (eff == 0 || xfer == 0) begin
            chk("zero_write_start", o_write_start, 0);
            chk("zero_busy", o_busy, 1);
            @(negedge aclk);
            chk("zero_done_at_2", ap_done, 1);
            chk("zero_busy_drop", o_busy, 0);
        end else begin
            for (int p = 0; p < eff && !err; p++) begin
                lat = 0;
                while (!o_write_start && lat < 16) begin @(negedge aclk); lat++; cyc++; end
                chk("write_start_seen", o_write_start, 1);
                if (!o_write_start) err = 1'b1;
                if (p == 0) chk("write_start_latency", cyc, 1);
                src = (p % 2) ? pb : pa;
                dst = (p % 2) ? pa : pb;
                chk("write_addr", o_write_addr, dst);
                chk("pass_idx", o_pass_idx, p);
                chk("init_pass", o_init_pass, (p == 0));
                r  = run_len(p, xfer);
                ng = int'((xfer + L * r - 1) / (L * r));
                for (int g = 0; g < ng && !err; g++) begin
                    lat = 0;
                    while (!o_read_start && lat < 16) begin @(negedge aclk); lat++; cyc++; end
                    chk("read_start_seen", o_read_start, 1);
                    if (!o_read_start) err = 1'b1;
                    if (p == 0 && g == 0) chk("read_start_latency", cyc, 3);
                    exp_rs++;
                    for (int l = 0; l < L; l++) begin
                        off = longint'(g) * L * r + longint'(l) * r;
                        if (off >= xfer) eb = 0;
                        else eb = (xfer - off < r) ? (xfer - off) : r;
                        ea = src + 64'(off);
                        chk($sformatf("leaf_addr p%0d g%0d l%0d", p, g, l),
                            o_leaf_addr[l*AW +: AW], ea);
                        chk($sformatf("leaf_bytes p%0d g%0d l%0d", p, g, l),
                            o_leaf_bytes[l*XW +: XW], 64'(eb));
                    end
                    last = (g == ng - 1);
                    mode = (wmode < 0) ? int'($urandom % 3) : wmode;
                    @(negedge aclk);
                    if (poke && p == 0 && g == 0) begin
                        ap_start = 1'b1;
                        i_xfer_bytes = {$urandom, $urandom};
                        i_ptr_src = {$urandom, $urandom};
                        i_num_pass = 8'($urandom);
                        @(negedge aclk);
                        ap_start = 1'b0;
                    end
                    repeat ($urandom % 3) @(negedge aclk);
                    if (last && mode == 2) begin
                        i_write_done = 1'b1; @(negedge aclk); i_write_done = 1'b0;
                    end
                    i_read_done = 1'b1;
                    if (last && mode == 1) i_write_done = 1'b1;
                    @(negedge aclk);
                    i_read_done = 1'b0; i_write_done = 1'b0;
                    if (last && mode == 0) begin
                        i_read_done = 1'b1; @(negedge aclk); i_read_done = 1'b0;
                        chk("stray_read_done_ignored", o_write_start, 0);
                        repeat ($urandom % 3) @(negedge aclk);
                        i_write_done = 1'b1; @(negedge aclk); i_write_done = 1'b0;
                    end
                end
            end
            lat = 0;
            while (!err && !ap_done && lat < 16) begin @(negedge aclk); lat++; end
            chk("done_seen", ap_done, 1);
            if (!ap_done) err = 1'b1;
            chk("busy_low_at_done", o_busy, 0);
            @(negedge aclk);
            chk("done_single_pulse", ap_done, 0);
        end
        @(negedge aclk);
        chk("read_start_count", rs_cnt - rs0, exp_rs);
        chk("write_start_count", ws_cnt - ws0, eff == 0 || xfer == 0 ? 0 : eff);
        chk("done_count", dn_cnt - dn0, 1);
        if (err) pulse_reset();
    endtask

    initial begin
        int lat, dn0;
        longint rx;
        int rn;
        // Reset state
        repeat (2) @(negedge aclk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", ap_done, 0);
        chk("rst_read_start", o_read_start, 0);
        chk("rst_write_start", o_write_start, 0);
        chk("rst_leaf_addr", |o_leaf_addr, 0);
        chk("rst_leaf_bytes", |o_leaf_bytes, 0);
        chk("rst_write_addr", o_write_addr, 0);
        ap_rst_n = 1'b1;
        @(negedge aclk);

        // Nominal two-pass job, partial last group, zero jobs, simultaneous dones
        run_job(4096, 2, 64'h1000, 64'h9000, 0, 1'b0);
        run_job(0,    3, 64'h1000, 64'h9000, 0, 1'b0);
        run_job(4096, 0, 64'h1000, 64'h9000, 0, 1'b0);
        run_job(4160, 2, 64'h1000, 64'h9000, 2, 1'b0);
        run_job(4096, 2, 64'h2000, 64'hA000, 1, 1'b1);
        run_job(1024, 10, 64'h4000, 64'h8000, -1, 1'b0);

        // Reset while waiting on a group read
        @(negedge aclk);
        i_num_pass = 8'd2; i_ptr_src = 64'h1000; i_ptr_dst = 64'h9000; i_xfer_bytes = 64'd4096;
        ap_start = 1'b1;
        @(negedge aclk);
        ap_start = 1'b0;
        lat = 0;
        while (!o_read_start && lat < 16) begin @(negedge aclk); lat++; end
        chk("rst_test_read_start", o_read_start, 1);
        @(negedge aclk);
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_leaf_addr", |o_leaf_addr, 0);
        chk("midrst_leaf_bytes", |o_leaf_bytes, 0);
        chk("midrst_write_addr", o_write_addr, 0);
        chk("midrst_init_pass", o_init_pass, 0);
        chk("midrst_pass_idx", o_pass_idx, 0);
        @(negedge aclk);
        ap_rst_n = 1'b1;
        dn0 = dn_cnt;
        repeat (6) @(negedge aclk);
        chk("midrst_no_done", dn_cnt - dn0, 0);
        run_job(4096, 2, 64'h1000, 64'h9000, 0, 1'b0);

`ifdef MERGE_SEQ_PERF_CNT_EN
        @(negedge aclk);
        i_num_pass = 8'd1; i_ptr_src = 64'h0; i_ptr_dst = 64'h10000; i_xfer_bytes = 64'd64;
        ap_start = 1'b1;
        @(negedge aclk);
        ap_start = 1'b0;
        chk("perf_write_start", o_write_start, 1);
        repeat (3) @(negedge aclk);
        i_read_done = 1'b1; @(negedge aclk); i_read_done = 1'b0;
        repeat (96) @(negedge aclk);
        i_write_done = 1'b1; @(negedge aclk); i_write_done = 1'b0;
        chk("perf_pass_cycles", o_pass_cycles, 100);
        lat = 0;
        while (!ap_done && lat < 16) begin @(negedge aclk); lat++; end
        chk("perf_done", ap_done, 1);
        chk("perf_total_cycles", o_total_cycles, 103);
`endif

        // Randomised jobs
        for (int j = 0; j < 16; j++) begin
            rx = longint'(INIT) * $urandom_range(0, 120);
            rn = int'($urandom_range(0, 10));
            run_job(rx, rn, {$urandom, $urandom} & ~64'h3F, {$urandom, $urandom} & ~64'h3F,
                    -1, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
